line_fifo_ram: RTL and testbench
================================

// Module: line_fifo_ram
// PURPOSE
//  Parametrised synchronous FIFO built on an inferred simple dual-port RAM.
//  Buffers pixel/line data between a producer (camera/DMA side) and a consumer (display/AHB side).
//  Adds over the plain RAM: managed wrap-around pointers, full/empty/almost-full status,
//  occupancy count, synchronous flush and a registered (1-cycle) read port.
// PARAMETERS
//  WIDTH    16      data word width in bits
//  DEPTH    1500    number of words stored; any value 2..2**DEPBIT (non-power-of-2 allowed)
//  DEPBIT   11      pointer/address width; must satisfy 2**DEPBIT >= DEPTH
//  AFULL_TH 1496    afull asserts when count >= AFULL_TH
// PORTS
//  clk       in   1          single clock; all logic on posedge clk
//  rst       in   1          synchronous, active-high reset
//  flush     in   1          synchronous clear of FIFO state (memory contents untouched)
//  wr_en     in   1          write request
//  wr_data   in   WIDTH      write data
//  full      out  1          count == DEPTH
//  afull     out  1          count >= AFULL_TH
//  rd_en     in   1          read request
//  rd_data   out  WIDTH      registered read data
//  rd_valid  out  1          rd_data holds a word popped on the previous cycle
//  empty     out  1          count == 0
//  count     out  DEPBIT+1   words currently stored, 0..DEPTH
//  ovf       out  1          (FIFO_ERR_FLAG_EN only) sticky: write attempted while full
//  udf       out  1          (FIFO_ERR_FLAG_EN only) sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst=1): wptr=rptr=0, count=0, empty=1, full=0, afull=0, rd_valid=0, rd_data=0,
//    ovf=udf=0. RAM contents are not reset. rst overrides flush, wr_en, rd_en.
//  - flush=1 (rst=0): same as reset except rd_data holds its value; flush overrides wr/rd same cycle.
//  - Write accept: wr_en && !full (full sampled at start of cycle). mem[wptr] <= wr_data, 0-based index.
//  - Read accept: rd_en && !empty. rd_data <= mem[rptr] next edge; rd_valid=1 for exactly that cycle.
//    Read latency = 1 cycle. Non-accepted cycles: rd_valid=0, rd_data holds last value.
//  - Pointer wrap: ptr == DEPTH-1 -> 0, else ptr+1. No power-of-2 masking.
//  - count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
//  - Simultaneous at full: read accepted, write rejected (count -> DEPTH-1).
//  - Simultaneous at empty: write accepted, read rejected (no write-to-read bypass; rd_valid=0).
//  - Same-address read/write in one cycle is impossible (requires count 0 or DEPTH, both blocked).
//  - full/empty/afull are registered-derived from count; all update on the same edge as count.
//  - Rejected requests are silently dropped; no internal state changes.
// CONFIGURATION
//  `define FIFO_ERR_FLAG_EN present: ovf/udf ports exist; ovf set on wr_en&&full, udf set on
//    rd_en&&empty; sticky until rst or flush.
//  Absent: ovf/udf ports removed; rejected requests leave no trace.
// TESTING
//  1. rst=1 2 cycles -> empty=1, full=0, afull=0, count=0, rd_valid=0, rd_data=0.
//  2. Write 0x0001..0x0004, then rd_en 4 cycles -> rd_data 0x0001..0x0004 one cycle after each
//     rd_en, rd_valid high 4 cycles, empty=1 and count=0 after last pop.
//  3. DEPTH=1500: write 1500 words -> afull at count=1496, full at 1500; 1501st write dropped,
//     ovf=1 (macro on); drain returns 1500 words in order, last = word 1500.
//  4. Wrap: write 1000, read 1000, write 1000 more (wptr crosses 1499->0) -> read back in order.
//  5. At full, wr_en+rd_en same cycle -> count=1499, oldest word out; at empty, both -> count=1,
//     rd_valid=0, udf=1 (macro on).
//  6. flush mid-stream (count=37) with wr_en=1 -> count=0, empty=1, rd_valid=0, ovf/udf cleared,
//     next write/read returns the new word only.

Source files
------------

// File: rtl/line_fifo_ram.sv
// Synchronous FIFO on an inferred simple dual-port RAM with a registered read port.
// Optional sticky overflow/underflow flags are enabled by `define FIFO_ERR_FLAG_EN.
module line_fifo_ram #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 1500,
    parameter int DEPBIT   = 11,
    parameter int AFULL_TH = 1496
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              full,
    output logic              afull,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic [DEPBIT:0]   count
`ifdef FIFO_ERR_FLAG_EN
    ,
    output logic              ovf,
    output logic              udf
`endif
);

    localparam logic [DEPBIT-1:0] LAST_PTR = (DEPBIT)'(DEPTH - 1);
    localparam logic [DEPBIT:0]   DEPTH_C  = (DEPBIT + 1)'(DEPTH);
    localparam logic [DEPBIT:0]   AFULL_C  = (DEPBIT + 1)'(AFULL_TH);

    logic [WIDTH-1:0]  r_mem [0:DEPTH-1];
    logic [DEPBIT-1:0] r_wptr;
    logic [DEPBIT-1:0] r_rptr;
    logic [DEPBIT:0]   r_count;
    logic              r_full;
    logic              r_afull;
    logic              r_empty;
    logic              r_rd_valid;
    logic [WIDTH-1:0]  r_rd_data;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DEPBIT-1:0] w_wptr_nxt;
    logic [DEPBIT-1:0] w_rptr_nxt;
    logic [DEPBIT:0]   w_cnt_nxt;

    // Acceptance uses the registered flags, i.e. the state at the start of the cycle.
    assign w_wr_acc   = wr_en && !r_full;
    assign w_rd_acc   = rd_en && !r_empty;
    assign w_wptr_nxt = (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_cnt_nxt = r_count + 1'b1;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_cnt_nxt = r_count - 1'b1;
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_wr_acc) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_empty    <= 1'b1;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else if (flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_empty    <= 1'b1;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_rd_acc) begin
                r_rptr    <= w_rptr_nxt;
                r_rd_data <= r_mem[r_rptr];
            end
            r_rd_valid <= w_rd_acc;
            r_count    <= w_cnt_nxt;
            r_full     <= (w_cnt_nxt == DEPTH_C);
            r_afull    <= (w_cnt_nxt >= AFULL_C);
            r_empty    <= (w_cnt_nxt == '0);
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr_en && r_full) begin
                r_ovf <= 1'b1;
            end
            if (rd_en && r_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`endif

    assign full     = r_full;
    assign afull    = r_afull;
    assign empty    = r_empty;
    assign count    = r_count;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_line_fifo_ram.sv
// Self-checking bench for line_fifo_ram: reference queue model plus a scoreboard of expected pops.
// Checks ovf/udf when built with `define FIFO_ERR_FLAG_EN.
module tb_line_fifo_ram;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 1500;
    localparam int DEPBIT   = 11;
    localparam int AFULL_TH = 1496;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              full;
    logic              afull;
    logic              rd_en;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              empty;
    logic [DEPBIT:0]   count;
`ifdef FIFO_ERR_FLAG_EN
    logic              ovf;
    logic              udf;
`endif

    line_fifo_ram #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .DEPBIT   (DEPBIT),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .afull    (afull),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .count    (count)
`ifdef FIFO_ERR_FLAG_EN
        ,
        .ovf      (ovf),
        .udf      (udf)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state and scoreboard
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_last;
    logic             m_ovf;
    logic             m_udf;
    logic             exp_rv;
    int               n_checks;
    int               n_pass;
    logic [WIDTH-1:0] wr_seq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [WIDTH-1:0] e;
        check("count", 32'(count), 32'(m_q.size()));
        check("empty", 32'(empty), 32'(m_q.size() == 0));
        check("full", 32'(full), 32'(m_q.size() == DEPTH));
        check("afull", 32'(afull), 32'(m_q.size() >= AFULL_TH));
        check("rd_valid", 32'(rd_valid), 32'(exp_rv));
        if (exp_rv) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(e));
            end
        end else begin
            check("rd_data_hold", 32'(rd_data), 32'(m_last));
        end
`ifdef FIFO_ERR_FLAG_EN
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("udf", 32'(udf), 32'(m_udf));
`endif
    endtask

    // driver: one clock cycle of stimulus, model update, then post-edge checks
    task automatic step(input logic wr, input logic [WIDTH-1:0] d, input logic rd, input logic fl);
        logic w_acc;
        logic r_acc;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        flush   = fl;
        exp_rv  = 1'b0;
        if (fl) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            w_acc = wr && (m_q.size() < DEPTH);
            r_acc = rd && (m_q.size() > 0);
            if (wr && m_q.size() == DEPTH) m_ovf = 1'b1;
            if (rd && m_q.size() == 0) m_udf = 1'b1;
            if (r_acc) begin
                m_last = m_q.pop_front();
                exp_q.push_back(m_last);
                exp_rv = 1'b1;
            end
            if (w_acc) m_q.push_back(d);
        end
        @(posedge clk);
        #1;
        check_outputs();
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        m_q.delete();
        exp_q.delete();
        m_last = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        exp_rv = 1'b0;
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) begin
            wr_seq++;
            step(1'b1, wr_seq, 1'b0, 1'b0);
        end
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        wr_seq   = '0;
        m_last   = '0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        exp_rv   = 1'b0;
        rst      = 1'b1;
        flush    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_data  = '0;

        // reset state
        do_reset();

        // basic write 1..4, read back
        write_n(4);
        read_n(4);
        check("drained_seq", 32'(m_last), 32'h0004);

        // fill to full, one dropped write, drain in order
        wr_seq = '0;
        write_n(DEPTH);
        step(1'b1, 16'hdead, 1'b0, 1'b0);
        read_n(DEPTH);
        check("last_word", 32'(m_last), 32'(DEPTH));

        // wrap across the non-power-of-2 end of the buffer
        write_n(1000);
        read_n(1000);
        write_n(1000);
        read_n(1000);

        // simultaneous read/write at full and at empty
        write_n(DEPTH);
        wr_seq++;
        step(1'b1, wr_seq, 1'b1, 1'b0);
        read_n(DEPTH - 1);
        wr_seq++;
        step(1'b1, wr_seq, 1'b1, 1'b0);
        read_n(1);

        // flush mid-stream with write and read requested
        write_n(37);
        step(1'b1, 16'hbeef, 1'b1, 1'b1);
        step(1'b1, 16'h5a5a, 1'b0, 1'b0);
        read_n(1);
        check("post_flush_word", 32'(m_last), 32'h5a5a);

        // random mixed traffic with occasional flushes
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0));
        end

        // reset mid-stream
        write_n(5);
        do_reset();
        read_n(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
